spi_frame_receiver: RTL and testbench

- SPI slave front end feeding the system controller.
- Receives 32-bit command words (control_state, memory_address, memory_data_out fields) from the external host over mode-0 SPI, oversampled in the core clock domain.
- Presents each complete word on spi_data with an active-low latch strobe (latch_data_sn).
- Shifts a readback word out on miso during the same frame.

---
 rtl/spi_frame_receiver_pkg.sv | 19 +
 rtl/spi_sync_edge.sv | 40 ++++
 rtl/spi_frame_receiver.sv | 172 +++++++++++++++++
 tb/tb_spi_frame_receiver.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/spi_frame_receiver_pkg.sv
// Shared definitions for the SPI frame receiver: word width, command-word
// field positions and the receiver FSM state encoding.
package spi_frame_receiver_pkg;

   localparam int SPI_WORD_WIDTH = 32;

   // Command word fields, MSB positions (control / address / data)
   localparam int CTRL_MSB = 31;
   localparam int ADDR_MSB = 23;
   localparam int DATA_MSB = 15;

   // 2'b11 is unused and falls back to IDLE in the FSM default branch
   typedef enum logic [1:0] {
      ST_IDLE  = 2'b00,
      ST_SHIFT = 2'b01,
      ST_LATCH = 2'b10
   } rx_state_e;

endpackage

// File: rtl/spi_sync_edge.sv
// Multi-stage synchronizer for one asynchronous SPI pin, followed by an
// edge-detect register. The level and the rise/fall pulses are registered
// together so they stay cycle-aligned with each other.
module spi_sync_edge #(
   parameter int   STAGES    = 2,
   parameter logic RESET_VAL = 1'b0
) (
   input  logic clock,
   input  logic reset_n,
   input  logic async_i,
   output logic level_o,
   output logic rise_o,
   output logic fall_o
);

   logic [STAGES-1:0] sync_q;
   logic              edge_q;
   logic              rise_q;
   logic              fall_q;

   // Synchronizer chain, previous-value register and edge pulses
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         sync_q <= {STAGES{RESET_VAL}};
         edge_q <= RESET_VAL;
         rise_q <= 1'b0;
         fall_q <= 1'b0;
      end else begin
         sync_q <= {sync_q[STAGES-2:0], async_i};
         edge_q <= sync_q[STAGES-1];
         rise_q <= sync_q[STAGES-1] & ~edge_q;
         fall_q <= ~sync_q[STAGES-1] & edge_q;
      end
   end

   assign level_o = edge_q;
   assign rise_o  = rise_q;
   assign fall_o  = fall_q;

endmodule

// File: rtl/spi_frame_receiver.sv
// Mode-0 SPI slave, oversampled in the core clock domain. Captures one
// command word per chip-select frame, presents it on spi_data with an
// active-low latch strobe, and shifts a readback word out on miso.
//
// state | meaning
// IDLE  | waiting for a fresh chip-select fall
// SHIFT | frame active: sample mosi on sclk rise, advance miso on sclk fall
// LATCH | word accepted, latch_data_sn held low for LATCH_CYCLES cycles
module spi_frame_receiver
   import spi_frame_receiver_pkg::*;
#(
   parameter int WORD_WIDTH   = SPI_WORD_WIDTH,
   parameter int SYNC_STAGES  = 2,
   parameter int LATCH_CYCLES = 4
) (
   input  logic                  clock,
   input  logic                  reset_n,
   input  logic                  enable_sn,
   input  logic                  sclk,
   input  logic                  cs_n,
   input  logic                  mosi,
   output logic                  miso,
   input  logic [WORD_WIDTH-1:0] readback_data,
   output logic [WORD_WIDTH-1:0] spi_data,
   output logic                  latch_data_sn,
   output logic                  frame_error
);

   // Bit counter saturates one past a full word so over-long frames stay wrong
   localparam int               CNT_W    = $clog2(WORD_WIDTH + 2);
   localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(WORD_WIDTH);
   localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(WORD_WIDTH + 1);
   localparam int               LAT_W    = $clog2(LATCH_CYCLES + 1);
   localparam logic [LAT_W-1:0] LAT_LOAD = LAT_W'(LATCH_CYCLES - 1);

   logic sclk_rise, sclk_fall, sclk_level_unused;
   logic cs_rise, cs_fall, cs_level_unused;
   logic mosi_s, mosi_rise_unused, mosi_fall_unused;

   spi_sync_edge #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_sclk (
      .clock   (clock),
      .reset_n (reset_n),
      .async_i (sclk),
      .level_o (sclk_level_unused),
      .rise_o  (sclk_rise),
      .fall_o  (sclk_fall)
   );

   spi_sync_edge #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_sync_cs (
      .clock   (clock),
      .reset_n (reset_n),
      .async_i (cs_n),
      .level_o (cs_level_unused),
      .rise_o  (cs_rise),
      .fall_o  (cs_fall)
   );

   spi_sync_edge #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_mosi (
      .clock   (clock),
      .reset_n (reset_n),
      .async_i (mosi),
      .level_o (mosi_s),
      .rise_o  (mosi_rise_unused),
      .fall_o  (mosi_fall_unused)
   );

   rx_state_e               state_q;
   logic [WORD_WIDTH-1:0]   rx_shift_q, rx_shift_d;
   logic [WORD_WIDTH-1:0]   tx_shift_q, tx_shift_d;
   logic [CNT_W-1:0]        bit_cnt_q, bit_cnt_d;
   logic [LAT_W-1:0]        latch_cnt_q;
   logic [WORD_WIDTH-1:0]   spi_data_q;
   logic                    latch_sn_q;
   logic                    frame_error_q;
   logic                    miso_q;

   // Shift-register next values; a same-cycle sclk rise is folded in before
   // the chip-select rise checks the bit count
   always_comb begin
      rx_shift_d = rx_shift_q;
      bit_cnt_d  = bit_cnt_q;
      tx_shift_d = tx_shift_q;
      if (sclk_rise) begin
         rx_shift_d = {rx_shift_q[WORD_WIDTH-2:0], mosi_s};
         if (bit_cnt_q != CNT_MAX) begin
            bit_cnt_d = bit_cnt_q + 1'b1;
         end
      end
      if (sclk_fall) begin
         tx_shift_d = {tx_shift_q[WORD_WIDTH-2:0], 1'b0};
      end
   end

   // Frame FSM with registered outputs; enable_sn acts as a synchronous clear
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_q       <= ST_IDLE;
         rx_shift_q    <= '0;
         tx_shift_q    <= '0;
         bit_cnt_q     <= '0;
         latch_cnt_q   <= '0;
         spi_data_q    <= '0;
         latch_sn_q    <= 1'b1;
         frame_error_q <= 1'b0;
         miso_q        <= 1'b0;
      end else if (enable_sn) begin
         state_q       <= ST_IDLE;
         bit_cnt_q     <= '0;
         latch_cnt_q   <= '0;
         latch_sn_q    <= 1'b1;
         frame_error_q <= 1'b0;
         miso_q        <= 1'b0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               latch_sn_q <= 1'b1;
               miso_q     <= 1'b0;
               if (cs_fall) begin
                  state_q    <= ST_SHIFT;
                  bit_cnt_q  <= '0;
                  rx_shift_q <= '0;
                  tx_shift_q <= readback_data;
                  miso_q     <= readback_data[WORD_WIDTH-1];
               end
            end
            ST_SHIFT: begin
               rx_shift_q <= rx_shift_d;
               bit_cnt_q  <= bit_cnt_d;
               tx_shift_q <= tx_shift_d;
               miso_q     <= tx_shift_d[WORD_WIDTH-1];
               if (cs_rise) begin
                  miso_q <= 1'b0;
                  if (bit_cnt_d == CNT_FULL) begin
                     spi_data_q    <= rx_shift_d;
                     frame_error_q <= 1'b0;
                     latch_cnt_q   <= LAT_LOAD;
                     latch_sn_q    <= 1'b0;
                     state_q       <= ST_LATCH;
                  end else begin
                     frame_error_q <= 1'b1;
                     state_q       <= ST_IDLE;
                  end
               end
            end
            ST_LATCH: begin
               miso_q <= 1'b0;
               // A frame starting under the strobe is dropped, not captured
               if (cs_fall) begin
                  frame_error_q <= 1'b1;
               end
               if (latch_cnt_q == '0) begin
                  latch_sn_q <= 1'b1;
                  state_q    <= ST_IDLE;
               end else begin
                  latch_cnt_q <= latch_cnt_q - 1'b1;
               end
            end
            default: begin
               state_q    <= ST_IDLE;
               latch_sn_q <= 1'b1;
               miso_q     <= 1'b0;
            end
         endcase
      end
   end

   assign spi_data      = spi_data_q;
   assign latch_data_sn = latch_sn_q;
   assign frame_error   = frame_error_q;
   assign miso          = miso_q;

endmodule

// File: tb/tb_spi_frame_receiver.sv
// Bench for spi_frame_receiver: directed test-plan frames plus randomized
// frames, checked against a frame-level model of expected word, error flag,
// strobe timing and readback bits.
module tb_spi_frame_receiver;
   import spi_frame_receiver_pkg::*;

   localparam int W          = SPI_WORD_WIDTH;
   localparam int SYNC       = 2;
   localparam int LATCH      = 4;
   localparam int STROBE_LAT = SYNC + 2;
   localparam int HALF       = 8;

   logic         clock = 1'b0;
   logic         reset_n = 1'b0;
   logic         enable_sn = 1'b0;
   logic         sclk = 1'b0;
   logic         cs_n = 1'b1;
   logic         mosi = 1'b0;
   logic         miso;
   logic [W-1:0] readback_data = '0;
   logic [W-1:0] spi_data;
   logic         latch_data_sn;
   logic         frame_error;

   int           n_tests = 0;
   int           n_fail = 0;
   logic [W-1:0] exp_data = '0;
   logic         exp_err = 1'b0;
   logic [W-1:0] miso_word;
   int           miso_bits;

   always #5 clock = ~clock;

   spi_frame_receiver #(
      .WORD_WIDTH   (W),
      .SYNC_STAGES  (SYNC),
      .LATCH_CYCLES (LATCH)
   ) dut (
      .clock         (clock),
      .reset_n       (reset_n),
      .enable_sn     (enable_sn),
      .sclk          (sclk),
      .cs_n          (cs_n),
      .mosi          (mosi),
      .miso          (miso),
      .readback_data (readback_data),
      .spi_data      (spi_data),
      .latch_data_sn (latch_data_sn),
      .frame_error   (frame_error)
   );

   task automatic check_val(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   task automatic wait_cyc(input int n);
      repeat (n) @(negedge clock);
   endtask

   // Sends bits[nbits-1] first; samples miso just before each sclk rise
   task automatic shift_bits(input logic [W:0] bits, input int nbits);
      for (int i = nbits - 1; i >= 0; i--) begin
         mosi = bits[i];
         wait_cyc(HALF);
         if (miso_bits < W) begin
            miso_word = {miso_word[W-2:0], miso};
            miso_bits++;
         end
         sclk = 1'b1;
         wait_cyc(HALF);
         sclk = 1'b0;
      end
      wait_cyc(HALF);
   endtask

   // Raises cs_n and measures the strobe that follows against the model
   task automatic finish_frame(input bit expect_strobe);
      int first;
      int cnt;
      first = -1;
      cnt = 0;
      cs_n = 1'b1;
      for (int k = 1; k <= 12; k++) begin
         wait_cyc(1);
         if (!latch_data_sn) begin
            if (first < 0) begin
               first = k;
               check_val("data_at_strobe", spi_data, exp_data);
            end
            cnt++;
         end
      end
      if (expect_strobe) begin
         check_val("strobe_start", first, STROBE_LAT);
         check_val("strobe_len", cnt, LATCH);
      end else begin
         check_val("no_strobe", cnt, 0);
      end
      check_val("spi_data", spi_data, exp_data);
      check_val("frame_error", 32'(frame_error), 32'(exp_err));
      check_val("miso_idle", 32'(miso), 32'd0);
   endtask

   task automatic run_frame(input logic [W:0] bits, input int nbits, input logic [W-1:0] rb);
      logic [W-1:0] exp_miso;
      readback_data = rb;
      miso_word = '0;
      miso_bits = 0;
      cs_n = 1'b0;
      shift_bits(bits, nbits);
      if (nbits == W) begin
         exp_data = bits[W-1:0];
         exp_err  = 1'b0;
      end else begin
         exp_err  = 1'b1;
      end
      exp_miso = (nbits >= W) ? rb : (rb >> (W - nbits));
      finish_frame(nbits == W);
      check_val("miso_word", miso_word, exp_miso);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [W-1:0] good;
      int           first;
      int           cnt;
      int           len_tab [4];
      len_tab = '{31, 32, 33, 32};

      wait_cyc(3);
      check_val("rst_spi_data", spi_data, 32'h0);
      check_val("rst_latch", 32'(latch_data_sn), 32'd1);
      check_val("rst_miso", 32'(miso), 32'd0);
      check_val("rst_err", 32'(frame_error), 32'd0);
      reset_n = 1'b1;
      wait_cyc(3);

      // Basic frame with readback pattern, then field layout
      run_frame({1'b0, 32'h012A_BEEF}, 32, 32'hA5C3_0F0F);
      check_val("ctrl_field", 32'(spi_data[CTRL_MSB -: 8]), 32'h01);
      check_val("addr_field", 32'(spi_data[ADDR_MSB -: 8]), 32'h2A);
      check_val("data_field", 32'(spi_data[DATA_MSB -: 16]), 32'hBEEF);

      // Short and long frames are rejected, then a good one clears the error
      run_frame({1'b0, 32'hFFFF_FFFE} >> 1, 31, 32'h1234_5678);
      run_frame({32'h0123_4567, 1'b1}, 33, 32'h8765_4321);
      run_frame({1'b0, 32'h0200_0001}, 32, 32'hFFFF_0000);

      // Randomized frames of varying length
      for (int n = 0; n < 6; n++) begin
         logic [W-1:0] d;
         logic [W-1:0] rb;
         int           len;
         d   = $urandom;
         rb  = $urandom;
         len = len_tab[$urandom_range(0, 3)];
         run_frame({d, 1'b0} >> (33 - len), len, rb);
      end

      // New frame starts one cycle after a good frame ends (under the strobe)
      good = $urandom;
      readback_data = $urandom;
      miso_word = '0;
      miso_bits = 0;
      cs_n = 1'b0;
      shift_bits({1'b0, good}, 32);
      exp_data = good;
      exp_err  = 1'b0;
      cs_n = 1'b1;
      first = -1;
      cnt = 0;
      for (int k = 1; k <= 12; k++) begin
         wait_cyc(1);
         if (k == 1) cs_n = 1'b0;
         if (!latch_data_sn) begin
            if (first < 0) first = k;
            cnt++;
         end
      end
      check_val("coll_strobe_start", first, STROBE_LAT);
      check_val("coll_strobe_len", cnt, LATCH);
      check_val("coll_spi_data", spi_data, exp_data);
      check_val("coll_err_early", 32'(frame_error), 32'd1);
      shift_bits({1'b0, ~good}, 32);
      exp_err = 1'b1;
      finish_frame(1'b0);

      // Enable abort part-way through a frame
      cs_n = 1'b0;
      shift_bits({21'h0, 12'hABC}, 12);
      enable_sn = 1'b1;
      wait_cyc(3);
      check_val("abort_spi_data", spi_data, exp_data);
      check_val("abort_latch", 32'(latch_data_sn), 32'd1);
      check_val("abort_miso", 32'(miso), 32'd0);
      enable_sn = 1'b0;
      exp_err = 1'b0;
      shift_bits({13'h0, 20'hFFFFF}, 20);
      finish_frame(1'b0);
      run_frame({1'b0, 32'h0311_0042}, 32, 32'h5A5A_A5A5);

      // Reset while the strobe is active
      good = $urandom;
      readback_data = $urandom;
      cs_n = 1'b0;
      shift_bits({1'b0, good}, 32);
      cs_n = 1'b1;
      wait_cyc(STROBE_LAT + 1);
      check_val("pre_reset_latch", 32'(latch_data_sn), 32'd0);
      check_val("pre_reset_data", spi_data, good);
      reset_n = 1'b0;
      #1;
      check_val("reset_latch", 32'(latch_data_sn), 32'd1);
      check_val("reset_data", spi_data, 32'h0);
      exp_data = '0;
      exp_err  = 1'b0;
      wait_cyc(2);
      reset_n = 1'b1;
      wait_cyc(4);
      check_val("post_reset_data", spi_data, 32'h0);
      run_frame({1'b0, 32'h0C0F_FEE5}, 32, 32'h0F1E_2D3C);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
